// File: rtl/mod_10_counter.sv
// rtl/mod_10_counter.sv - free-running modulo-N counter with terminal-count flag
// Counts 0..MODULUS-1 on every rising edge; tc marks the last state for cascading.
module mod_10_counter #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             w_at_last;

  assign w_at_last = (r_count == LP_LAST);

  // Anything at or past the last state (including unreachable codes) returns to 0.
  always_comb begin
    w_count_next = r_count + WIDTH'(1);
    if (r_count >= LP_LAST) begin
      w_count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;
  assign tc    = w_at_last;

endmodule

// File: tb/tb_mod_10_counter.sv
// tb/tb_mod_10_counter.sv - scoreboard bench for mod_10_counter (MODULUS 10 and 6)
// Stimulus pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_mod_10_counter;

  logic       clk;
  logic       reset;
  logic [3:0] count10;
  logic       tc10;
  logic [2:0] count6;
  logic       tc6;

  typedef struct packed {
    logic [3:0] c10;
    logic       t10;
    logic [2:0] c6;
    logic       t6;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 0;
  int   exp10 = 0;
  int   exp6  = 0;

  mod_10_counter #(.MODULUS(10), .WIDTH(4)) dut10 (
    .clk   (clk),
    .reset (reset),
    .count (count10),
    .tc    (tc10)
  );

  mod_10_counter #(.MODULUS(6), .WIDTH(3)) dut6 (
    .clk   (clk),
    .reset (reset),
    .count (count6),
    .tc    (tc6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Drive reset for one edge, then push the expected post-edge outputs.
  task automatic step(input logic r);
    exp_t e;
    reset = r;
    @(posedge clk);
    #1;
    exp10 = r ? 0 : ((exp10 == 9) ? 0 : exp10 + 1);
    exp6  = r ? 0 : ((exp6 == 5) ? 0 : exp6 + 1);
    e.c10 = 4'(exp10);
    e.t10 = (exp10 == 9);
    e.c6  = 3'(exp6);
    e.t6  = (exp6 == 5);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Hand-computed decade sequence after the power-up reset edge (edges 5..115 ns).
  int seq10 [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int seq6  [12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count10", int'(count10), int'(e.c10));
      chk("tc10",    int'(tc10),    int'(e.t10));
      chk("count6",  int'(count6),  int'(e.c6));
      chk("tc6",     int'(tc6),     int'(e.t6));
      if (count10 > 4'd9) begin
        n_bad++;
        $display("FAIL range10 at %0t: got %0d, expected <= 9", $time, count10);
      end
    end
  end

  initial begin
    reset = 1'b1;
    step(1'b1);
    for (int i = 1; i < 12; i++) step(1'b0);
    // Directed check of the first 12 edges against the hand table.
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        chk("tbl_c10_0", int'(count10), seq10[11]);
        chk("tbl_c6_0",  int'(count6),  seq6[11]);
      end
    end
    // Mid-sequence reset at 120 ns, release at 130 ns.
    step(1'b1);
    chk("midrst_c10", int'(count10), 0);
    chk("midrst_tc10", int'(tc10), 0);
    step(1'b0);
    chk("resume_c10", int'(count10), 1);
    for (int i = 0; i < 4; i++) step(1'b0);
    // Held reset across 5 edges.
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk("held_c10", int'(count10), 0);
      chk("held_c6",  int'(count6),  0);
    end
    step(1'b0);
    chk("release_c10", int'(count10), 1);
    chk("release_c6",  int'(count6),  1);
    // Long free run through many wraps.
    for (int i = 0; i < 115; i++) step(1'b0);
    repeat (2) @(negedge clk);
    stim_done = 1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stuck, expected completion");
    $fatal(1);
  end

endmodule
